serial_twos_comp_alu: RTL and testbench



---
 rtl/serial_twos_comp_alu.sv | 136 +++++++++++++
 tb/tb_serial_twos_comp_alu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_comp_alu.sv
// Bit-serial LSB-first ALU: pass, negate, add or subtract on framed WIDTH-bit words,
// with stall tolerance and signed-overflow reporting on the MSB output cycle.
module serial_twos_comp_alu #(
    parameter int WIDTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       bit_valid,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       out_bit,
    output logic       out_valid,
    output logic       out_last,
    output logic       overflow,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          carry_q, carry_d;
    logic [1:0]    op_q, op_d;
    logic          out_bit_q, out_bit_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;

    logic [1:0]    eff_op;
    logic [CW-1:0] cur_count;
    logic          accept;
    logic          is_msb;
    logic          carry_in;
    logic          x, y, s, cout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && is_msb) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    // The start cycle may itself carry bit 0, so op, count and carry come from the
    // raw inputs/initial values while IDLE and from the latched state while RUN.
    always_comb begin
        eff_op    = (state_q == IDLE) ? op : op_q;
        cur_count = (state_q == IDLE) ? '0 : count_q;
        accept    = bit_valid && ((state_q == RUN) || start);
        is_msb    = (cur_count == LAST);
        carry_in  = (state_q == IDLE) ? op[0] : carry_q;
        if (eff_op == 2'b00) carry_in = 1'b0;
        case (eff_op)
            2'b00:   begin x = a_bit;  y = 1'b0;   end
            2'b01:   begin x = ~a_bit; y = 1'b0;   end
            2'b10:   begin x = a_bit;  y = b_bit;  end
            default: begin x = a_bit;  y = ~b_bit; end
        endcase
        s    = x ^ y ^ carry_in;
        cout = (x & y) | (x & carry_in) | (y & carry_in);
    end

    always_comb begin
        count_d = count_q;
        carry_d = carry_q;
        op_d    = op_q;
        if ((state_q == IDLE) && start) begin
            op_d    = op;
            count_d = '0;
            carry_d = op[0];
        end
        if (accept) begin
            if (is_msb) begin
                count_d = '0;
                carry_d = 1'b0;
            end else begin
                count_d = cur_count + CW'(1);
                carry_d = cout;
            end
        end
        out_valid_d = accept;
        out_bit_d   = accept & s;
        out_last_d  = accept & is_msb;
        done_d      = accept & is_msb;
        overflow_d  = accept & is_msb & (eff_op != 2'b00) & (carry_in ^ cout);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            carry_q     <= 1'b0;
            op_q        <= 2'b00;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_twos_comp_alu.sv
// Bench for serial_twos_comp_alu: directed words checked every cycle against an
// integer-arithmetic model, plus literal expectations for each directed word.
module tb_serial_twos_comp_alu;

    localparam int W = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic       bit_valid;
    logic       a_bit;
    logic       b_bit;
    logic       out_bit;
    logic       out_valid;
    logic       out_last;
    logic       overflow;
    logic       busy;
    logic       done;

    serial_twos_comp_alu #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
        .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
        .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] word;
        logic         ov;
    } exp_t;

    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    logic         tb_feed = 1'b0;
    logic         exp_v;
    exp_t         exp_q[$];
    int           idx = 0;
    logic [W-1:0] got_word = '0;
    logic [W-1:0] last_word = '0;
    logic [W-1:0] prev_word = '0;
    logic         last_ov = 1'b0;
    int           done_count = 0;
    int           done_cyc = 0;
    int           start_cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Result and overflow from signed integer arithmetic on the whole word.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        int   sa, sb, res;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        case (o)
            2'b00:   res = sa;
            2'b01:   res = -sa;
            2'b10:   res = sa + sb;
            default: res = sa - sb;
        endcase
        r.word = W'(res);
        r.ov   = (res > (1 << (W - 1)) - 1) || (res < -(1 << (W - 1)));
        return r;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) exp_v <= 1'b0;
        else       exp_v <= tb_feed;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            idx = 0;
            exp_q.delete();
            checkOutput("reset_outputs", {26'd0, out_bit, out_valid, out_last, overflow, busy, done}, 32'd0);
        end else begin
            checkOutput("out_valid", out_valid, exp_v);
            checkOutput("done_eq_last", done, out_last);
            if (out_valid) begin
                checkOutput("pending_word", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    checkOutput("out_bit", out_bit, exp_q[0].word[idx]);
                    checkOutput("out_last", out_last, idx == W - 1);
                    got_word[idx] = out_bit;
                    if (idx == W - 1) begin
                        checkOutput("overflow", overflow, exp_q[0].ov);
                        checkOutput("busy_at_last", busy, 0);
                        prev_word = last_word;
                        last_word = got_word;
                        last_ov   = overflow;
                        done_count++;
                        done_cyc  = cyc;
                        void'(exp_q.pop_front());
                        idx = 0;
                    end else begin
                        checkOutput("busy_mid_word", busy, 1);
                        idx++;
                    end
                end
            end else begin
                checkOutput("idle_flags", {29'd0, out_last, done, overflow}, 32'd0);
            end
        end
    end

    task automatic drive(input logic s, input logic [1:0] o, input logic bv,
                         input logic a, input logic b, input logic feed);
        start = s; op = o; bit_valid = bv; a_bit = a; b_bit = b; tb_feed = feed;
        @(posedge clock);
        #1;
    endtask

    // Streams one word; stall_mask marks cycles (after the start cycle) with bit_valid=0.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [15:0] stall_mask, input logic poke);
        int i;
        int c;
        exp_q.push_back(model(o, a, b));
        start_cyc = cyc;
        drive(1'b1, o, 1'b1, a[0], b[0], 1'b1);
        i = 1;
        c = 1;
        while (i < W) begin
            if (stall_mask[c]) begin
                drive(poke, 2'b01, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
            end else begin
                drive(poke, poke ? ~o : o, 1'b1, a[i], b[i], 1'b1);
                i++;
            end
            c++;
        end
    endtask

    task automatic finishWord(input string name, input logic [W-1:0] w, input logic ov);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({name, "_word"}, last_word, w);
        checkOutput({name, "_ov"}, last_ov, ov);
    endtask

    exp_t m;
    int   dc;

    initial begin
        reset = 1'b1;
        start = 1'b0; op = 2'b00; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state", {26'd0, out_bit, out_valid, out_last, overflow, busy, done}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        m = model(2'b01, 8'hBB, 8'h00); checkOutput("model_neg_bb", {23'd0, m}, {23'd0, 8'h45, 1'b0});
        m = model(2'b01, 8'h80, 8'h00); checkOutput("model_neg_80", {23'd0, m}, {23'd0, 8'h80, 1'b1});
        m = model(2'b11, 8'h05, 8'h07); checkOutput("model_sub",    {23'd0, m}, {23'd0, 8'hFE, 1'b0});
        m = model(2'b10, 8'h7F, 8'h01); checkOutput("model_add_ov", {23'd0, m}, {23'd0, 8'h80, 1'b1});

        drive(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(2'b01, 8'hBB, 8'h00, 16'h0000, 1'b0);
        finishWord("neg_bb", 8'h45, 1'b0);
        checkOutput("start_to_done_cycles", done_cyc - start_cyc, 8);

        applyStimulus(2'b01, 8'h80, 8'h00, 16'h0000, 1'b0);
        finishWord("neg_80", 8'h80, 1'b1);
        applyStimulus(2'b01, 8'h00, 8'h00, 16'h0000, 1'b0);
        finishWord("neg_00", 8'h00, 1'b0);
        applyStimulus(2'b11, 8'h05, 8'h07, 16'h0000, 1'b0);
        finishWord("sub_5_7", 8'hFE, 1'b0);
        applyStimulus(2'b10, 8'h7F, 8'h01, 16'h0000, 1'b0);
        finishWord("add_7f_1", 8'h80, 1'b1);
        applyStimulus(2'b00, 8'hA5, 8'hFF, 16'h0000, 1'b0);
        finishWord("pass_a5", 8'hA5, 1'b0);

        applyStimulus(2'b10, 8'h12, 8'h34, 16'b0000_0000_0110_0100, 1'b1);
        finishWord("add_stall", 8'h46, 1'b0);

        applyStimulus(2'b11, 8'h03, 8'h01, 16'h0000, 1'b0);
        applyStimulus(2'b01, 8'h01, 8'h00, 16'h0000, 1'b0);
        finishWord("b2b_second", 8'hFF, 1'b0);
        checkOutput("b2b_first_word", prev_word, 8'h02);

        dc = done_count;
        exp_q.push_back(model(2'b10, 8'h0F, 8'h01));
        drive(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        tb_feed = 1'b0; start = 1'b0; bit_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_clear", {26'd0, out_bit, out_valid, out_last, overflow, busy, done}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("no_done_after_abort", done_count, dc);

        applyStimulus(2'b11, 8'h40, 8'hC0, 16'h0000, 1'b0);
        finishWord("sub_after_reset", 8'h80, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("all_words_out", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
